fork_join_ctrl: RTL

FORK_JOIN_CTRL -- requirements
Module: fork_join_ctrl

---
 rtl/fork_join_ctrl_pkg.sv | 36 +++
 rtl/fork_join_ctrl_if.sv | 26 ++
 rtl/fj_thread_timer.sv | 60 ++++++
 rtl/fork_join_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/fork_join_ctrl_pkg.sv
// Shared types and helpers for the fork/join thread controller.
// Included by fork_join_ctrl and its testbench; no configuration macros here.
package fork_join_pkg;

  typedef enum logic [1:0] {
    JOIN      = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

  localparam int MAX_THR = 16;

  // Encoding 3 is reserved and behaves as a full join.
  function automatic join_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return JOIN_ANY;
      2'd2:    return JOIN_NONE;
      default: return JOIN;
    endcase
  endfunction

  function automatic int lowest_set(input logic [MAX_THR-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_THR - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fork_join_ctrl_if.sv
// Launch/status bundle between a thread requester (master) and fork_join_ctrl (slave).
interface fork_join_ctrl_if #(
  parameter int N_THR = 4,
  parameter int CNT_W = 8
);
  logic                       start;
  logic [1:0]                 mode;
  logic [N_THR-1:0]           thr_en;
  logic [N_THR*CNT_W-1:0]     delay;
  logic                       abort;
  logic                       busy;
  logic [N_THR-1:0]           thr_active;
  logic [N_THR-1:0]           thr_done;
  logic                       join_done;
  logic [$clog2(N_THR)-1:0]   first_id;

  modport master (
    output start, mode, thr_en, delay, abort,
    input  busy, thr_active, thr_done, join_done, first_id
  );

  modport slave (
    input  start, mode, thr_en, delay, abort,
    output busy, thr_active, thr_done, join_done, first_id
  );
endinterface

// File: rtl/fj_thread_timer.sv
// One hardware thread: saturating down-counter with a registered active flag and done pulse.
// fire/active_nxt expose the next-edge values so the controller can align join_done.
module fj_thread_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay,
  output logic             active,
  output logic             done,
  output logic             fire,
  output logic             active_nxt
);

  logic [CNT_W-1:0] cnt, cnt_nxt;

  // A delay of 0 or 1 completes on the launch edge itself.
  always_comb begin
    cnt_nxt    = cnt;
    active_nxt = active;
    fire       = 1'b0;
    if (abort) begin
      cnt_nxt    = '0;
      active_nxt = 1'b0;
    end else if (load && en) begin
      if (delay <= CNT_W'(1)) begin
        cnt_nxt    = '0;
        active_nxt = 1'b0;
        fire       = 1'b1;
      end else begin
        cnt_nxt    = delay - CNT_W'(1);
        active_nxt = 1'b1;
      end
    end else if (active) begin
      if (cnt <= CNT_W'(1)) begin
        cnt_nxt    = '0;
        active_nxt = 1'b0;
        fire       = 1'b1;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      active <= active_nxt;
      done   <= fire;
    end
  end

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches N_THR timed threads and signals when the join policy is met.
// Define FORK_JOIN_TRACE_EN to print a line per thread completion and per join.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int N_THR = 4,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  fork_join_ctrl_if.slave bus
);

  localparam int ID_W = $clog2(N_THR);

  fsm_state_e       state;
  join_mode_e       mode_q, mode_eff;
  logic             launch, joined, first_seen, join_done_q;
  logic             any_fire, all_done, join_nxt;
  logic [N_THR-1:0] act, act_nxt, done, fire;
  logic [ID_W-1:0]  first_id_q, fire_id;

  assign launch = bus.start && (state == IDLE) && !bus.abort;

  for (genvar i = 0; i < N_THR; i++) begin : g_thr
    fj_thread_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (launch),
      .en         (bus.thr_en[i]),
      .abort      (bus.abort),
      .delay      (bus.delay[i*CNT_W +: CNT_W]),
      .active     (act[i]),
      .done       (done[i]),
      .fire       (fire[i]),
      .active_nxt (act_nxt[i])
    );
  end

  // Decide whether the edge that registers this cycle's completions also satisfies the join.
  always_comb begin
    mode_eff = launch ? decode_mode(bus.mode) : mode_q;
    any_fire = |fire;
    all_done = any_fire && (act_nxt == '0);
    fire_id  = ID_W'(lowest_set(MAX_THR'(fire)));
    join_nxt = 1'b0;
    if (launch && (bus.thr_en == '0)) begin
      join_nxt = 1'b1;
    end else if (launch || ((state == RUN) && !bus.abort && !joined)) begin
      case (mode_eff)
        JOIN_NONE: join_nxt = launch;
        JOIN_ANY:  join_nxt = any_fire;
        default:   join_nxt = all_done;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= JOIN;
      joined      <= 1'b0;
      first_seen  <= 1'b0;
      first_id_q  <= '0;
      join_done_q <= 1'b0;
    end else begin
      join_done_q <= join_nxt;
      if (launch) begin
        mode_q     <= mode_eff;
        joined     <= join_nxt;
        first_seen <= any_fire;
        first_id_q <= any_fire ? fire_id : '0;
        state      <= (bus.thr_en != '0) ? RUN : IDLE;
      end else if (state == RUN) begin
        if (join_nxt) joined <= 1'b1;
        if (any_fire && !first_seen) begin
          first_seen <= 1'b1;
          first_id_q <= fire_id;
        end
        if (bus.abort || (act == '0)) state <= IDLE;
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.thr_active = act;
  assign bus.thr_done   = done;
  assign bus.join_done  = join_done_q;
  assign bus.first_id   = first_id_q;

`ifdef FORK_JOIN_TRACE_EN
  always @(posedge clk) begin
    for (int i = 0; i < N_THR; i++) begin
      if (done[i]) $display("[%0t] Thread%0d done", $time, i);
    end
    if (join_done_q) $display("[%0t] join_done", $time);
  end
`else
  // Silent build: cycle behaviour is unchanged, only the trace is absent.
`endif

endmodule
